dds_ddc_center_axis_stall_detect: RTL and testbench
===================================================

DDS_DDC_CENTER_AXIS_STALL_DETECT -- requirements
Module: dds_ddc_center_axis_stall_detect

Interface
REQ-001 The block SHALL take parameter NCH, default 4, the number of AXIS channels monitored.
REQ-002 The block SHALL take parameter CNT_W, default 16, the per-channel stall counter width.
REQ-003 The block SHALL take parameter STALL_THRESH, default 1024, the consecutive stall cycles that flag a block; legal range 1..2^CNT_W-1.
REQ-004 clock  input  1  single clock, rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 axis_tvalid  input  NCH  TVALID of each monitored stream.
REQ-007 axis_tready  input  NCH  TREADY of each monitored stream.
REQ-008 clear  input  1  single-cycle pulse; clears flags, counters and first-block capture.
REQ-009 axis_block_sigs  output  NCH  per-channel blocked flag; feeds the deadlock monitor's axis_block_sigs input.
REQ-010 first_ch  output  clog2(NCH)  index of the first channel to block since reset or clear.
REQ-011 first_valid  output  1  first_ch holds a captured index.
REQ-012 block_events  output  16  count of channel entries into BLOCKED, saturating at 0xFFFF.

Function
REQ-013 A channel SHALL be stalled in a cycle when its axis_tvalid=1 and its axis_tready=0.
REQ-014 Each channel SHALL run an independent FSM with states IDLE, COUNT and BLOCKED.
REQ-015 In IDLE, a stall cycle SHALL load the counter with 1 and move to COUNT; otherwise the FSM SHALL stay in IDLE with the counter at 0.
REQ-016 In COUNT, a stall cycle SHALL increment the counter; a non-stall cycle SHALL zero it and return to IDLE.
REQ-017 From COUNT, when a stall cycle finds the counter at STALL_THRESH-1, the FSM SHALL enter BLOCKED at that edge.
REQ-018 With STALL_THRESH=1, the FSM SHALL enter BLOCKED directly from IDLE on the first stall cycle.
REQ-019 axis_block_sigs[i] SHALL be registered, equal to (state==BLOCKED), and first high STALL_THRESH cycles after the first stall cycle of an unbroken run.
REQ-020 In BLOCKED, the counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 From BLOCKED, a non-stall cycle SHALL return the FSM to IDLE with the counter at 0, and the flag SHALL drop at that edge (non-sticky build).
REQ-022 On the first IDLE/COUNT-to-BLOCKED entry while first_valid=0, first_ch and first_valid SHALL be captured.
REQ-023 When several channels enter BLOCKED in the same cycle, first_ch SHALL take the lowest index.
REQ-024 first_ch/first_valid SHALL hold until reset or clear.
REQ-025 block_events SHALL add the number of channels entering BLOCKED in that cycle (0..NCH), saturating at 0xFFFF.
REQ-026 clear SHALL force every FSM to IDLE, every counter and block_events to 0, and first_valid to 0, overriding any stall or entry in the same cycle.
REQ-027 The block SHALL NOT drive or modify axis_tvalid or axis_tready; monitoring is passive.

Reset
REQ-028 On reset=1 at a rising edge, all FSMs SHALL go to IDLE and all counters to 0.
REQ-029 Reset SHALL set axis_block_sigs=0, first_ch=0, first_valid=0 and block_events=0.
REQ-030 Reset asserted mid-stall or in BLOCKED SHALL discard all progress; counting restarts from 0 after release.

Configuration
REQ-031 With STALL_DETECT_STICKY_EN defined, BLOCKED SHALL be left only by reset or clear, and non-stall cycles SHALL NOT lower axis_block_sigs[i].
REQ-032 With STALL_DETECT_STICKY_EN defined, block_events SHALL count each channel at most once per reset/clear interval.
REQ-033 Without STALL_DETECT_STICKY_EN, behaviour SHALL be as in REQ-021 and REQ-025.

Verification (NCH=4, CNT_W=16, STALL_THRESH=8)
REQ-034 ch1 valid=1, ready=0 for 8 cycles from cycle 10 -> block_sigs=4'b0010 from cycle 18; first_ch=1; first_valid=1; block_events=1.
REQ-035 ch0 stalls 7 cycles, 1 transfer cycle, then stalls 7 more -> block_sigs stays 0 and block_events=0.
REQ-036 ch2 and ch3 start stalling in the same cycle, 8 cycles -> block_sigs=4'b1100 together; first_ch=2; block_events=2.
REQ-037 ch1 blocked, ready=1 for 1 cycle -> non-sticky: flag low next cycle; STALL_DETECT_STICKY_EN: flag stays high until a clear pulse, then 0.
REQ-038 ch0 stalls 70000 cycles -> flag stays high and counter holds 0xFFFF (no wrap); then reset mid-stall -> all outputs 0 next cycle, flag high again 8 stall cycles after release.
REQ-039 clear on the same cycle ch3 would enter BLOCKED -> block_sigs=0, first_valid=0, block_events=0.

Source files
------------

// File: rtl/dds_ddc_center_axis_stall_detect.sv
// Passive per-channel AXIS stall detector: flags channels stalled for STALL_THRESH consecutive cycles.
// Optional build macro STALL_DETECT_STICKY_EN makes BLOCKED flags sticky until reset or clear.
module dds_ddc_center_axis_stall_detect #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 16,
    parameter int STALL_THRESH = 1024,
    localparam int IDX_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   axis_tvalid,
    input  logic [NCH-1:0]   axis_tready,
    input  logic             clear,
    output logic [NCH-1:0]   axis_block_sigs,
    output logic [IDX_W-1:0] first_ch,
    output logic             first_valid,
    output logic [15:0]      block_events
);

    // state   | meaning
    // IDLE    | no stall in progress, counter 0
    // COUNT   | unbroken stall run shorter than STALL_THRESH
    // BLOCKED | stall run reached STALL_THRESH, flag high
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   stall;
    logic [NCH-1:0]   entry;

    logic [IDX_W-1:0] first_ch_d;
    logic             first_valid_d;
    logic [15:0]      block_events_d;

    assign stall = axis_tvalid & ~axis_tready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            entry[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (stall[i]) begin
                        cnt_d[i]   = CNT_W'(1);
                        state_d[i] = (STALL_THRESH == 1) ? BLOCKED : COUNT;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                COUNT: begin
                    if (stall[i]) begin
                        cnt_d[i] = (cnt_q[i] != CNT_MAX) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
                        if (cnt_q[i] == THRESH_M1) begin
                            state_d[i] = BLOCKED;
                        end
                    end else begin
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end
                end
                BLOCKED: begin
                    if (stall[i]) begin
                        cnt_d[i] = (cnt_q[i] != CNT_MAX) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
                    end else begin
                        cnt_d[i] = '0;
`ifdef STALL_DETECT_STICKY_EN
                        state_d[i] = BLOCKED;
`else
                        state_d[i] = IDLE;
`endif
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            // Sticky build never leaves BLOCKED, so each channel enters at most once per interval.
            entry[i] = (state_q[i] != BLOCKED) && (state_d[i] == BLOCKED);
        end
    end

    always_comb begin
        logic [16:0]      sum;
        logic             found;
        logic [IDX_W-1:0] idx;
        sum   = {1'b0, block_events};
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            sum = sum + 17'(entry[i]);
            if (entry[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        block_events_d = sum[16] ? 16'hFFFF : sum[15:0];
        first_ch_d     = first_ch;
        first_valid_d  = first_valid;
        if (!first_valid && found) begin
            first_ch_d    = idx;
            first_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            first_ch     <= '0;
            first_valid  <= 1'b0;
            block_events <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            first_ch     <= first_ch_d;
            first_valid  <= first_valid_d;
            block_events <= block_events_d;
        end
    end

    always_comb begin
        axis_block_sigs = '0;
        for (int i = 0; i < NCH; i++) begin
            axis_block_sigs[i] = (state_q[i] == BLOCKED);
        end
    end

endmodule

// File: tb/tb_dds_ddc_center_axis_stall_detect.sv
// Directed bench for dds_ddc_center_axis_stall_detect (NCH=4, CNT_W=16, STALL_THRESH=8).
module tb_dds_ddc_center_axis_stall_detect;

`ifdef STALL_DETECT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  axis_tvalid;
    logic [3:0]  axis_tready;
    logic        clear;
    logic [3:0]  axis_block_sigs;
    logic [1:0]  first_ch;
    logic        first_valid;
    logic [15:0] block_events;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  ready;
        logic        clr;
        int          cycles;
        logic [3:0]  blk;
        logic        fv;
        logic [1:0]  fc;
        logic [15:0] ev;
    } vec_t;

    vec_t vecs[$];

    dds_ddc_center_axis_stall_detect #(
        .NCH(4), .CNT_W(16), .STALL_THRESH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready),
        .clear(clear),
        .axis_block_sigs(axis_block_sigs),
        .first_ch(first_ch),
        .first_valid(first_valid),
        .block_events(block_events)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] blk, input logic fv,
                             input logic [1:0] fc, input logic [15:0] ev);
        check({name, ".block_sigs"}, int'(axis_block_sigs), int'(blk));
        check({name, ".first_valid"}, int'(first_valid), int'(fv));
        if (fv) check({name, ".first_ch"}, int'(first_ch), int'(fc));
        check({name, ".block_events"}, int'(block_events), int'(ev));
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        clear       = 1'b0;
        axis_tvalid = '0;
        axis_tready = '0;

        // valid, ready, clr, cycles, blk, fv, fc, ev
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 3, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b0010, 4'b0000, 1'b0, 7, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b0010, 4'b0000, 1'b0, 1, 4'b0010, 1'b1, 2'd1, 16'd1});
        vecs.push_back('{4'b0010, 4'b0000, 1'b0, 5, 4'b0010, 1'b1, 2'd1, 16'd1});
        vecs.push_back('{4'b0010, 4'b0010, 1'b0, 1, STICKY ? 4'b0010 : 4'b0000, 1'b1, 2'd1, 16'd1});
        vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b0001, 4'b0000, 1'b0, 7, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b0001, 4'b0001, 1'b0, 1, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b0001, 4'b0000, 1'b0, 7, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b1100, 4'b0000, 1'b0, 7, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b1100, 4'b0000, 1'b0, 1, 4'b1100, 1'b1, 2'd2, 16'd2});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 1, STICKY ? 4'b1100 : 4'b0000, 1'b1, 2'd2, 16'd2});
        vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b1000, 4'b0000, 1'b0, 7, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b1000, 4'b0000, 1'b1, 1, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b1000, 4'b0000, 1'b0, 7, 4'b0000, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b1000, 4'b0000, 1'b0, 1, 4'b1000, 1'b1, 2'd3, 16'd1});
        vecs.push_back('{4'b1010, 4'b0000, 1'b0, 8, 4'b1010, 1'b1, 2'd3, 16'd2});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 1, STICKY ? 4'b1010 : 4'b0000, 1'b1, 2'd3, 16'd2});
        vecs.push_back('{4'b0010, 4'b0000, 1'b0, 8, STICKY ? 4'b1010 : 4'b0010, 1'b1, 2'd3,
                         STICKY ? 16'd2 : 16'd3});
        vecs.push_back('{4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 1'b0, 2'd0, 16'd0});

        run_cycles(2);
        check("reset.first_ch", int'(first_ch), 0);
        check_all("reset", 4'b0000, 1'b0, 2'd0, 16'd0);
        reset = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            axis_tvalid = vecs[v].valid;
            axis_tready = vecs[v].ready;
            clear       = vecs[v].clr;
            run_cycles(vecs[v].cycles);
            check_all($sformatf("vec%0d", v), vecs[v].blk, vecs[v].fv, vecs[v].fc, vecs[v].ev);
        end
        clear = 1'b0;

        // Long ch0 stall: flag must survive the counter reaching its maximum.
        axis_tvalid = 4'b0001;
        axis_tready = 4'b0000;
        run_cycles(8);
        check_all("long.enter", 4'b0001, 1'b1, 2'd0, 16'd1);
        run_cycles(65535 - 8);
        check_all("long.at_max", 4'b0001, 1'b1, 2'd0, 16'd1);
        run_cycles(70000 - 65535);
        check_all("long.past_max", 4'b0001, 1'b1, 2'd0, 16'd1);

        // Reset mid-stall discards all progress; stall keeps going through release.
        reset = 1'b1;
        run_cycles(1);
        check("rst_mid.first_ch", int'(first_ch), 0);
        check_all("rst_mid", 4'b0000, 1'b0, 2'd0, 16'd0);
        reset = 1'b0;
        run_cycles(7);
        check_all("rst_mid.seven", 4'b0000, 1'b0, 2'd0, 16'd0);
        run_cycles(1);
        check_all("rst_mid.eight", 4'b0001, 1'b1, 2'd0, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
